// File: rtl/prog_loader_pkg.sv
// Shared CPU definitions: instruction width, loader frame header, loader FSM states.
package prog_loader_pkg;
  localparam int INSTR_W = 27;
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } ld_state_t;
endpackage

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> program-memory writes; holds the core in reset until a good frame.
// One byte per cycle when rx_ready; PROM write one cycle after the 4th instruction byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter int         INSTR_W = prog_loader_pkg::INSTR_W,
  parameter logic [7:0] HDR     = prog_loader_pkg::HDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic               reload,
  output logic               pm_we,
  output logic [ADDR_W-1:0]  pm_waddr,
  output logic [INSTR_W-1:0] pm_wdata,
  output logic               core_rst,
  output logic               done,
  output logic               err
);

  localparam logic [16:0]   DEPTH   = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t state, state_nxt;

  logic [7:0]          len_hi;
  logic [ADDR_W:0]     len;
  logic [ADDR_W:0]     idx;
  logic [1:0]          byte_idx;
  logic [7:0]          chk;
  // Only the low INSTR_W-8 bits of the first three bytes survive into the word.
  logic [INSTR_W-9:0]  assembly;

  logic                accept;
  logic [16:0]         len_full;
  logic [ADDR_W:0]     idx_inc;

  assign accept   = rx_valid & rx_ready;
  assign len_full = {1'b0, len_hi, rx_data};
  assign idx_inc  = idx + IDX_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept && rx_data == HDR) state_nxt = S_LEN_HI;
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full > DEPTH)       state_nxt = S_ERR;
          else if (len_full == 17'd0) state_nxt = S_CHK;
          else                        state_nxt = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_idx == 2'd3 && idx_inc == len) state_nxt = S_CHK;
      S_CHK:    if (accept) state_nxt = (rx_data == chk) ? S_DONE : S_ERR;
      S_DONE:   if (reload) state_nxt = S_IDLE;
      S_ERR:    if (accept && rx_data == HDR) state_nxt = S_LEN_HI;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi   <= '0;
      len      <= '0;
      idx      <= '0;
      byte_idx <= '0;
      chk      <= '0;
      assembly <= '0;
      pm_we    <= 1'b0;
      pm_waddr <= '0;
      pm_wdata <= '0;
      rx_ready <= 1'b0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      pm_we <= 1'b0;
      if (accept) begin
        case (state)
          S_LEN_HI: begin
            len_hi <= rx_data;
            chk    <= rx_data;
          end
          S_LEN_LO: begin
            len      <= len_full[ADDR_W:0];
            chk      <= chk ^ rx_data;
            idx      <= '0;
            byte_idx <= '0;
          end
          S_DATA: begin
            chk      <= chk ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            assembly <= {assembly[INSTR_W-17:0], rx_data};
            if (byte_idx == 2'd3) begin
              pm_we    <= 1'b1;
              pm_waddr <= idx[ADDR_W-1:0];
              pm_wdata <= {assembly, rx_data};
              idx      <= idx_inc;
            end
          end
          default: ;
        endcase
      end
      // Status outputs track the state being entered so they are valid the cycle after the deciding edge.
      rx_ready <= (state_nxt != S_DONE);
      core_rst <= (state_nxt != S_DONE);
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected PROM writes queued as frames are sent, compared on pm_we.
module tb_prog_loader;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 27;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx_valid = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_ready;
  logic               reload = 1'b0;
  logic               pm_we;
  logic [ADDR_W-1:0]  pm_waddr;
  logic [INSTR_W-1:0] pm_wdata;
  logic               core_rst;
  logic               done;
  logic               err;

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .HDR(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .pm_we(pm_we), .pm_waddr(pm_waddr), .pm_wdata(pm_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  logic [ADDR_W-1:0]  exp_addr[$];
  logic [INSTR_W-1:0] exp_data[$];
  logic [31:0]        wbuf[1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pm_we === 1'b1) begin
      n_we++;
      if (exp_addr.size() == 0) check("unexpected_we", 32'd1, 32'd0);
      else begin
        check("waddr", 32'(pm_waddr), 32'(exp_addr.pop_front()));
        check("wdata", 32'(pm_wdata), 32'(exp_data.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int n, input logic [7:0] chk_xor);
    logic [7:0] c;
    logic [7:0] b;
    logic [15:0] l;
    l = 16'(len);
    c = l[15:8] ^ l[7:0];
    send_byte(8'hA5);
    send_byte(l[15:8]);
    send_byte(l[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_data.push_back(wbuf[i][INSTR_W-1:0]);
      for (int k = 3; k >= 0; k--) begin
        b = wbuf[i][8*k +: 8];
        c = c ^ b;
        send_byte(b);
      end
    end
    send_byte(c ^ chk_xor);
    rx_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clk);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload_core_rst", 32'(core_rst), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_pm_we"}, 32'(pm_we), 32'd0);
    check({tag, "_pm_waddr"}, 32'(pm_waddr), 32'd0);
    check({tag, "_pm_wdata"}, 32'(pm_wdata), 32'd0);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Garbage before header, empty program
    we0 = n_we;
    send_byte(8'h3C);
    send_byte(8'h11);
    send_frame(0, 0, 8'h00);
    expect_done("len0");
    check("len0_no_we", 32'(n_we - we0), 32'd0);
    do_reload();

    // Reference two-instruction frame
    wbuf[0] = 32'h01234567;
    wbuf[1] = 32'h07FFFFFF;
    send_frame(2, 2, 8'h00);
    expect_done("frame_a");
    do_reload();

    // Corrupted checksum, then a good frame straight from ERR
    send_frame(2, 2, 8'h01);
    expect_err("bad_chk");
    check("bad_chk_pending", 32'(exp_addr.size()), 32'd0);
    send_frame(2, 2, 8'h00);
    expect_done("after_err");
    do_reload();

    // Oversize length
    we0 = n_we;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    rx_valid = 1'b0;
    expect_err("oversize");
    check("oversize_no_we", 32'(n_we - we0), 32'd0);

    // Reset after the second instruction byte
    we0 = n_we;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h23);
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    check("mid_rst_no_we", 32'(n_we - we0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h00000001;
    wbuf[2] = 32'h12345678;
    send_frame(3, 3, 8'h00);
    expect_done("post_rst");
    do_reload();

    // Full-depth program
    for (int i = 0; i < 1024; i++) wbuf[i] = $urandom;
    send_frame(1024, 1024, 8'h00);
    expect_done("full_depth");

    // DONE ignores offered bytes
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("done_rx_ready", 32'(rx_ready), 32'd0);
    check("done_hold", 32'(done), 32'd1);
    rx_valid = 1'b0;
    do_reload();
    wbuf[0] = $urandom;
    send_frame(1, 1, 8'h00);
    expect_done("reloaded");

    check("final_pending", 32'(exp_addr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
